// File: rtl/hypot_arb_pkg.sv
// Shared types and constants for the hypotenuse-unit arbiter.
// Holds the FSM state encoding, operand/result widths and a width helper.
package hypot_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam int OPW  = 8;
  localparam int RESW = 32;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/hypot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The pointer must be below NREQ; NREQ need not be a power of two.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hypot_arbiter.sv
// Round-robin arbiter sharing one multi-cycle hypotenuse unit among NREQ requesters,
// with a watchdog that turns a hung unit into an error response.
module hypot_arbiter
  import hypot_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NREQ-1:0]     req_i,
  input  logic [OPW*NREQ-1:0] a_i,
  input  logic [OPW*NREQ-1:0] b_i,
  output logic [NREQ-1:0]     gnt_o,
  output logic [NREQ-1:0]     done_o,
  output logic [RESW-1:0]     y_o,
  output logic                err_o,
  output logic                busy_o,
  output logic                unit_start_o,
  output logic [OPW-1:0]      unit_a_o,
  output logic [OPW-1:0]      unit_b_o,
  input  logic                unit_busy_i,
  input  logic [RESW-1:0]     unit_y_i
);

  localparam int IW  = clog2_f(NREQ);
  localparam int WDW = clog2_f(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [WDW-1:0]  wd;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      wd           <= '0;
      gnt_o        <= '0;
      done_o       <= '0;
      y_o          <= '0;
      err_o        <= 1'b0;
      unit_start_o <= 1'b0;
      unit_a_o     <= '0;
      unit_b_o     <= '0;
    end else begin
      gnt_o        <= '0;
      done_o       <= '0;
      unit_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_o    <= pick_gnt;
            unit_a_o <= a_i[int'(pick_idx)*OPW +: OPW];
            unit_b_o <= b_i[int'(pick_idx)*OPW +: OPW];
            owner    <= pick_idx;
            ptr      <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          unit_start_o <= 1'b1;
          wd           <= '0;
          state        <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          // Expiry wins over a busy edge seen in the same cycle.
          if (wd == WDW'(TIMEOUT)) begin
            y_o    <= '0;
            err_o  <= 1'b1;
            done_o <= ONE << owner;
            state  <= RESP;
          end else begin
            wd <= wd + 1'b1;
            if (state == WAIT_BUSY) begin
              if (unit_busy_i) state <= WAIT_DONE;
            end else if (!unit_busy_i) begin
              y_o    <= unit_y_i;
              err_o  <= 1'b0;
              done_o <= ONE << owner;
              state  <= RESP;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hypot_arbiter.sv
// Randomized scoreboard bench for hypot_arbiter with a behavioural 20-cycle hypotenuse unit.
module tb_hypot_arbiter;

  localparam int N       = 4;
  localparam int TO      = 40;
  localparam int UNIT_LAT = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [N-1:0] req_drv = '0;
  logic [7:0]  aop [N];
  logic [7:0]  bop [N];
  logic [8*N-1:0] a_bus, b_bus;
  logic        hang = 1'b0;

  logic [N-1:0] gnt_o, done_o;
  logic [31:0]  y_o;
  logic         err_o, busy_o, unit_start_o;
  logic [7:0]   unit_a_o, unit_b_o;
  logic         ubusy = 1'b0;
  logic [31:0]  uy = '0;
  int           ucnt = 0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int idx;
    int y;
    bit err;
    int gcyc;
    int a;
    int b;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      a_bus[8*k +: 8] = aop[k];
      b_bus[8*k +: 8] = bop[k];
    end
  end

  hypot_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req_drv),
    .a_i          (a_bus),
    .b_i          (b_bus),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .y_o          (y_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .unit_start_o (unit_start_o),
    .unit_a_o     (unit_a_o),
    .unit_b_o     (unit_b_o),
    .unit_busy_i  (ubusy),
    .unit_y_i     (uy)
  );

  function automatic int isqrt(input int s);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic int ref_pick(input logic [N-1:0] pend, input int p);
    for (int i = 0; i < N; i++)
      if (pend[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Behavioural unit: busy rises the edge after start is sampled and stays high UNIT_LAT cycles.
  always @(posedge clk) begin
    if (ubusy) begin
      if (ucnt == 1) ubusy <= 1'b0;
      ucnt <= ucnt - 1;
    end else if (unit_start_o && !hang) begin
      ubusy <= 1'b1;
      ucnt  <= UNIT_LAT;
      uy    <= 32'(isqrt(int'(unit_a_o) * int'(unit_a_o) + int'(unit_b_o) * int'(unit_b_o)));
    end
  end

  // Monitor: predicts grants from the held request vector and scores every response.
  initial begin
    int ref_ptr;
    int k;
    exp_t e;
    ref_ptr = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        sbq.delete();
        ref_ptr = 0;
      end else begin
        if (gnt_o != '0) begin
          k = ref_pick(req_drv, ref_ptr);
          checks++;
          if (k < 0 || gnt_o != (N'(1) << k)) begin
            errors++;
            $display("FAIL gnt_order: got %b want index %0d (pending %b)", gnt_o, k, req_drv);
          end
          if (k >= 0) begin
            e.idx  = k;
            e.err  = hang;
            e.y    = hang ? 0 : isqrt(int'(aop[k]) * int'(aop[k]) + int'(bop[k]) * int'(bop[k]));
            e.gcyc = cyc;
            e.a    = int'(aop[k]);
            e.b    = int'(bop[k]);
            sbq.push_back(e);
            ref_ptr = (k + 1) % N;
          end
        end
        if (unit_start_o) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL start_pulse: start with no job outstanding at cycle %0d", cyc);
          end else if (cyc != sbq[$].gcyc + 1 || int'(unit_a_o) != sbq[$].a || int'(unit_b_o) != sbq[$].b) begin
            errors++;
            $display("FAIL start_pulse: cycle %0d a=%0d b=%0d, want cycle %0d a=%0d b=%0d",
                     cyc, unit_a_o, unit_b_o, sbq[$].gcyc + 1, sbq[$].a, sbq[$].b);
          end
        end
        if (done_o != '0) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: done=%b with no job outstanding", done_o);
          end else begin
            e = sbq.pop_front();
            if (done_o != (N'(1) << e.idx)) begin
              errors++;
              $display("FAIL done_owner: got %b want bit %0d", done_o, e.idx);
            end
            checks++;
            if (y_o != 32'(e.y)) begin
              errors++;
              $display("FAIL result_y: got %0d want %0d (req %0d)", y_o, e.y, e.idx);
            end
            checks++;
            if (err_o != e.err) begin
              errors++;
              $display("FAIL result_err: got %0d want %0d", err_o, e.err);
            end
            checks++;
            if (cyc - e.gcyc != (e.err ? TO + 2 : UNIT_LAT + 3)) begin
              errors++;
              $display("FAIL latency: got %0d want %0d", cyc - e.gcyc, e.err ? TO + 2 : UNIT_LAT + 3);
            end
          end
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    checks++;
    if (gnt_o != '0 || done_o != '0 || y_o != '0 || err_o || busy_o ||
        unit_start_o || unit_a_o != '0 || unit_b_o != '0) begin
      errors++;
      $display("FAIL %s: gnt=%b done=%b y=%0d err=%b busy=%b start=%b a=%0d b=%0d, want all 0",
               tag, gnt_o, done_o, y_o, err_o, busy_o, unit_start_o, unit_a_o, unit_b_o);
    end
  endtask

  task automatic wait_served();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      req_drv = req_drv & ~gnt_o;
      if (req_drv == '0 && sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL service_timeout: pending %b, %0d responses outstanding", req_drv, sbq.size());
      req_drv = '0;
    end
  endtask

  task automatic serve(input logic [N-1:0] mask);
    @(negedge clk);
    req_drv = req_drv | mask;
    wait_served();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      aop[k] = '0;
      bop[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk_zero("reset_state");

    aop[0] = 8'd3; bop[0] = 8'd4;
    rst_n = 1'b1;
    serve(4'b0001);

    // Contention with all requests already present when reset releases.
    @(negedge clk);
    rst_n = 1'b0;
    aop[0] = 8'd6; bop[0] = 8'd8;
    aop[1] = 8'd5; bop[1] = 8'd12;
    aop[2] = 8'd8; bop[2] = 8'd15;
    aop[3] = 8'd0; bop[3] = 8'd0;
    req_drv = 4'b1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_served();

    aop[2] = 8'd9;  bop[2] = 8'd40;
    serve(4'b0100);
    aop[0] = 8'd20; bop[0] = 8'd21;
    aop[2] = 8'd12; bop[2] = 8'd35;
    serve(4'b0101);

    hang = 1'b1;
    aop[0] = 8'd9; bop[0] = 8'd12;
    serve(4'b0001);
    hang = 1'b0;
    aop[1] = 8'd255; bop[1] = 8'd255;
    serve(4'b0010);

    for (int r = 0; r < 25; r++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        aop[k] = 8'($urandom);
        bop[k] = 8'($urandom);
      end
      serve(m);
    end

    // Asynchronous reset while the unit is mid-job.
    aop[0] = 8'd100; bop[0] = 8'd100;
    @(negedge clk);
    req_drv = 4'b0001;
    repeat (12) @(negedge clk);
    req_drv = '0;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    aop[1] = 8'd7; bop[1] = 8'd24;
    serve(4'b0010);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hypot_arbiter.md
Name: hypot_arbiter

Overview:
- Shares one multi-cycle hypotenuse unit among NREQ requesters. The unit computes floor(sqrt(a²+b²)) with a start pulse, a busy level and a 32-bit result.
- Picks requesters round-robin, latches their operands, sequences the unit's start/busy handshake and routes the result back to the owner.
- Includes a watchdog so a hung unit cannot deadlock the requesters.
- Sits between the core-side requesters and the single unit instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 255, max cycles spent in WAIT_BUSY plus WAIT_DONE before an error response.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  NREQ  per-requester request level
- a_i  in  8*NREQ  operand a, requester k at bits [8k+7:8k]
- b_i  in  8*NREQ  operand b, same packing
- gnt_o  out  NREQ  one-hot, one-cycle pulse: request k accepted, operands latched
- done_o  out  NREQ  one-hot, one-cycle pulse: result for k valid on y_o/err_o
- y_o  out  32  result, valid only while done_o != 0
- err_o  out  1  watchdog expired, valid only while done_o != 0
- busy_o  out  1  arbiter not in IDLE
- unit_start_o  out  1  start pulse to unit
- unit_a_o  out  8  latched operand a to unit
- unit_b_o  out  8  latched operand b to unit
- unit_busy_i  in  1  unit busy level
- unit_y_i  in  32  unit result, valid when busy falls

Behaviour:
- Reset (async, rst_ni=0): state IDLE, rr pointer 0. Outputs gnt_o, done_o, y_o, err_o, busy_o, unit_start_o, unit_a_o, unit_b_o, owner and watchdog counter all 0. Reset mid-operation abandons the job with no done_o; the unit is not reset by this block.
- IDLE, any req_i set:
  - Select the first set bit at or after the rr pointer, wrapping.
  - Pulse gnt_o[k], latch a_i/b_i slice k into unit_a_o/unit_b_o, record the owner.
  - Set the rr pointer to (k+1) mod NREQ. Go to ISSUE.
- ISSUE: unit_start_o=1 for exactly this cycle; clear the watchdog. Go to WAIT_BUSY.
- WAIT_BUSY: wait for unit_busy_i=1 (the unit raises busy the cycle after it samples start). Then go to WAIT_DONE.
- WAIT_DONE: on unit_busy_i=0, capture unit_y_i into y_o, clear err_o, go to RESP.
- Watchdog:
  - Increments every cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT: y_o=0, err_o=1, go to RESP. There is no retry.
  - Expiry takes precedence over a busy transition in the same cycle.
- RESP: done_o[owner]=1 for one cycle. Go to IDLE. No grant is issued in RESP.
- Minimum latency is grant (cycle 0) to done = unit latency + 3 cycles. Back-to-back grants are at least 4 cycles apart.
- unit_a_o/unit_b_o hold stable from grant until the next grant.
- Requester protocol:
  - req_i is sampled only in IDLE.
  - A requester must drop req the cycle after gnt. If req is still high in a later IDLE it is a new request.
  - A request dropped before grant is silently discarded.
- Simultaneous requests are ordered by the rr pointer only. Every requester is granted within NREQ jobs.
- busy_o = (state != IDLE).

Decomposition:
- Package hypot_arb_pkg holds:
  - state encoding: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3, RESP=4 (3 bits)
  - OPW=8, RESW=32
  - a function for clog2(NREQ)
- One sub-module, rr_pick: combinational round-robin picker. Inputs are the req vector and pointer; outputs are a one-hot grant and its index.
- The FSM, operand latches and watchdog live in hypot_arbiter.

Test Plan:
- Setup: the bench uses a behavioural unit model with busy high for 20 cycles, computing floor(sqrt(a²+b²)).
- Single request: req_i=0001, a=3, b=4 → gnt_o=0001 next edge, one unit_start_o pulse, done_o=0001 with y_o=5, err_o=0, 23 cycles after grant.
- Contention: req_i=1111 held at reset release, operands (6,8), (5,12), (8,15), (0,0) → grants in order 0,1,2,3; y_o=10, 13, 17, 0 each paired with the matching done_o bit.
- Round-robin fairness: after serving req 2, assert req_i=0101 → requester 0 is granted before requester 2.
- Timeout: model never raises busy → done_o for the owner exactly TIMEOUT+2 cycles after grant, with err_o=1 and y_o=0; the next request is served normally.
- Async reset: drop rst_ni during WAIT_DONE → all outputs 0 immediately, no done_o. After release, req_i=0010, a=7, b=24 → y_o=25.
